// File: rtl/dma_ctrl.sv
// Single-channel word DMA: a 4-register slave port programs SRC/DST/LEN/CTRL,
// and a master port copies LEN words, one read then one write per beat.
module dma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  output logic        irq_out
);

  // Master handshake: a request (read_out or write_out) is held, with stable
  // address and data, until the cycle ready_in=1; that edge completes the beat.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  state_t      state;
  state_t      state_next;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic [31:0] buffer;
  logic        done;
  logic        abort_pending;

  logic        busy;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        wr_src;
  logic        wr_dst;
  logic        wr_len;
  logic        ctrl_wr;
  logic        start_req;
  logic        go;
  logic        done_clr;
  logic        abort_req;
  logic        abort_hit;
  logic        rd_beat;
  logic        wr_beat;
  logic [15:0] len_next;
  logic [31:0] len_merged;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign busy      = (state == RD) || (state == WR);
  assign reg_sel   = address_in[3:2];
  // The slave bus has no write strobe: a selected non-read with any lane enabled is a write.
  assign wr_en     = sel_in && !read_in && (write_mask_in != 4'b0000);
  assign wr_src    = wr_en && (reg_sel == REG_SRC) && !busy;
  assign wr_dst    = wr_en && (reg_sel == REG_DST) && !busy;
  assign wr_len    = wr_en && (reg_sel == REG_LEN) && !busy;
  assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL) && write_mask_in[0];
  assign start_req = ctrl_wr && write_value_in[0];
  // START is only taken from IDLE; FIN is a single cycle and returns there.
  assign go        = start_req && (state == IDLE);
  assign done_clr  = ctrl_wr && write_value_in[2];
  assign abort_req = ctrl_wr && write_value_in[3] && busy;
  assign abort_hit = abort_pending || abort_req;
  assign rd_beat   = (state == RD) && ready_in;
  assign wr_beat   = (state == WR) && ready_in;
  assign len_next  = len - 16'd1;
  assign len_merged = merge_bytes({16'b0, len}, write_value_in, write_mask_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    address_out     = 32'b0;
    read_out        = 1'b0;
    write_out       = 1'b0;
    write_mask_out  = 4'b0000;
    write_value_out = 32'b0;
    case (state)
      IDLE: begin
        if (go && (len != 16'd0)) state_next = RD;
      end
      RD: begin
        address_out = {src[31:2], 2'b00};
        read_out    = 1'b1;
        if (ready_in) state_next = abort_hit ? IDLE : WR;
      end
      WR: begin
        address_out     = {dst[31:2], 2'b00};
        write_out       = 1'b1;
        write_mask_out  = 4'b1111;
        write_value_out = buffer;
        if (ready_in) begin
          if (abort_hit)                 state_next = IDLE;
          else if (len_next != 16'd0)    state_next = RD;
          else                           state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Register file; slave writes and beat updates never coincide because
  // SRC/DST/LEN writes are blocked while a beat can complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      src    <= 32'b0;
      dst    <= 32'b0;
      len    <= 16'b0;
      buffer <= 32'b0;
    end else begin
      if (wr_src) src <= merge_bytes(src, write_value_in, write_mask_in);
      if (wr_dst) dst <= merge_bytes(dst, write_value_in, write_mask_in);
      if (wr_len) len <= len_merged[15:0];
      if (rd_beat) buffer <= read_value_in;
      if (wr_beat) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len_next;
      end
    end
  end

  // DONE: the clear is applied first so a set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      done          <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      if (done_clr) done <= 1'b0;
      if (go) done <= (len == 16'd0);
      if (state == FIN) done <= 1'b1;

      if (abort_req) abort_pending <= 1'b1;
      if (state_next == IDLE) abort_pending <= 1'b0;
    end
  end

  always_comb begin
    read_value_out = 32'b0;
    if (sel_in) begin
      case (reg_sel)
        REG_SRC:  read_value_out = src;
        REG_DST:  read_value_out = dst;
        REG_LEN:  read_value_out = {16'b0, len};
        REG_CTRL: read_value_out = {28'b0, abort_pending, done, busy, 1'b0};
        default:  read_value_out = 32'b0;
      endcase
    end
  end

  assign ready_out = sel_in;
  assign irq_out   = done;

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 The block SHALL have one clock, `clk`, and one reset, `reset`; reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock (pll_clk domain).
- reset  in  1  synchronous active-high reset.
- address_in  in  32  slave bus address; bits[3:2] select the register.
- sel_in  in  1  slave select, decoded by top.
- read_in  in  1  slave read strobe.
- read_value_out  out  32  slave read data; 0 when sel_in=0.
- write_mask_in  in  4  slave byte write enables.
- write_value_in  in  32  slave write data.
- ready_out  out  1  slave ready.
- address_out  out  32  master address.
- read_out  out  1  master read request.
- write_out  out  1  master write request.
- write_mask_out  out  4  master byte enables.
- write_value_out  out  32  master write data.
- read_value_in  in  32  master read data.
- ready_in  in  1  master transfer complete.
- irq_out  out  1  level interrupt, equal to DONE.

Function
REQ-003 Registers SHALL be mapped by address_in[3:2]: 0 = SRC, 1 = DST, 2 = LEN[15:0], 3 = CTRL.
- CTRL bit0 START: write 1 starts a transfer.
- CTRL bit1 BUSY: read-only.
- CTRL bit2 DONE: write 1 clears it.
- CTRL bit3 ABORT: write 1 requests abort.
REQ-004 Slave writes SHALL honour each byte lane of write_mask_in independently; writes with a zero mask change nothing.
REQ-005 ready_out SHALL equal sel_in combinationally, with zero wait states.
REQ-006 read_value_out SHALL be the selected register when sel_in=1, and 0 otherwise; unused bits read 0.
REQ-007 Writes to SRC, DST or LEN while BUSY=1 SHALL be ignored.
REQ-008 A START write while BUSY=1 SHALL be ignored.
REQ-009 The FSM SHALL have states IDLE, RD, WR and FIN.
REQ-010 In IDLE, address_out, read_out, write_out, write_mask_out and write_value_out SHALL all be 0, so the block is OR-bus safe.
REQ-011 IDLE -> RD on a START write with LEN != 0; on that cycle BUSY=1 and DONE is cleared.
REQ-012 A START write with LEN == 0 SHALL set DONE=1 on the next cycle, stay in IDLE, and issue no bus cycle.
REQ-013 In RD: address_out = {src[31:2], 2'b00}, read_out=1; the state SHALL hold until ready_in=1, then capture read_value_in into the data buffer and go to WR.
REQ-014 In WR: address_out = {dst[31:2], 2'b00}, write_out=1, write_mask_out=4'b1111, write_value_out = buffer; the state SHALL hold until ready_in=1.
REQ-015 On WR completion: src += 4, dst += 4 (modulo 2^32 wrap), len -= 1; go to RD if the new len != 0, else to FIN.
REQ-016 FIN SHALL last one cycle: DONE=1, BUSY=0, then return to IDLE.
REQ-017 read_out and write_out SHALL never be asserted simultaneously, and a request SHALL stay stable until ready_in.
REQ-018 ABORT while BUSY SHALL let the in-flight RD or WR complete, then enter IDLE with DONE=0.
- Registers keep their partially advanced values.
- ABORT while idle SHALL have no effect.
REQ-019 ready_in while in IDLE or FIN SHALL be ignored.
REQ-020 If a DONE-clear write and FIN occur in the same cycle, the set SHALL win.
REQ-021 SRC, DST and LEN SHALL read back the live, advancing values during a transfer.

Reset
REQ-022 reset SHALL force:
- state IDLE;
- SRC, DST, LEN, buffer and DONE = 0;
- all master outputs and irq_out = 0.
REQ-023 reset asserted mid-transfer SHALL drop read_out and write_out on the next edge without completing the beat.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- SRC=0x100, DST=0x200, LEN=3, START; zero-wait memory -> 3 read/write pairs at 0x100/0x200, 0x104/0x204, 0x108/0x208; destination data equals source; DONE=1, irq_out=1, LEN=0, SRC=0x10C.
- LEN=0, START -> no read_out or write_out ever asserted; DONE=1 one cycle later.
- ready_in held low for 5 cycles during RD -> read_out and address_out stable for all 6 cycles; the data captured is the value present in the ready cycle.
- ABORT during the WR of beat 2 of a LEN=4 transfer -> the write completes, then IDLE with DONE=0, LEN=2, BUSY=0.
- Write to SRC, and a second START, while BUSY -> SRC unchanged; the transfer count is unaffected.
- reset pulse mid-RD -> next cycle: all master outputs 0, CTRL reads 0.
